ddr_addr_arbiter: RTL and testbench
===================================

// Module: ddr_addr_arbiter
// PURPOSE
//  Shares the single DDR address hold buffer between NUM_REQ requesters using round-robin arbitration.
//  Loads the winner's address into the buffer through address/write_enable.
//  Issues one command to the DDR command FSM, then holds ownership until the burst completes.
//  Sits between the host-side request ports and the address hold buffer / DDR command sequencer.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  ALIGN_BITS  2   low address bits that must be zero (used only with DDR_ARB_ERR_EN)
// PORTS
//  clk           in   1            system clock, rising edge
//  rst           in   1            asynchronous, active-high reset
//  req_valid     in   NUM_REQ      per-requester request; held until req_ack (or req_err)
//  req_addr      in   32*NUM_REQ   requester i address at [32*i +: 32]
//  req_write     in   NUM_REQ      1 = write burst, 0 = read burst
//  req_ack       out  NUM_REQ      one-hot, 1-cycle pulse: request accepted
//  address       out  32           to hold buffer: selected requester address
//  write_enable  out  1            to hold buffer: capture address this cycle
//  cmd_valid     out  1            command to DDR sequencer is pending
//  cmd_write     out  1            registered req_write of the granted requester
//  cmd_id        out  $clog2(NUM_REQ)  granted requester index
//  cmd_ready     in   1            sequencer accepts the command (valid&ready handshake)
//  cmd_done      in   1            1-cycle pulse: burst for the current command finished
//  busy          out  1            state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, rr_ptr=0, grant=0.
//    All outputs are 0: req_ack, address, write_enable, cmd_valid, cmd_write, cmd_id, busy.
//    Reset mid-operation abandons the command and drops cmd_valid immediately.
//  FSM states: IDLE -> LOAD -> ISSUE -> WAIT_DONE -> IDLE.
//  IDLE: if |req_valid:
//    grant <= first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    Register req_write[grant] into cmd_write; go to LOAD.
//  LOAD, exactly 1 cycle:
//    Drive address = req_addr[grant], write_enable=1, req_ack[grant]=1; go to ISSUE.
//    The hold buffer output is valid from the first ISSUE cycle.
//    If req_valid[grant]=0 in LOAD (protocol violation): abort. No write_enable, no ack,
//    return to IDLE, rr_ptr unchanged.
//  ISSUE: cmd_valid=1 and cmd_id=grant, held stable until cmd_ready=1; then go to WAIT_DONE.
//  WAIT_DONE: on cmd_done: go to IDLE, rr_ptr <= (grant+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0).
//    cmd_done outside WAIT_DONE is ignored, including a cmd_done coincident with cmd_ready in ISSUE.
//  address is 0 outside LOAD. write_enable is asserted only in LOAD, so the held address never
//    changes during ISSUE or WAIT_DONE.
//  Fairness: a continuously requesting port waits at most NUM_REQ-1 grants.
//  Minimum turnaround: req_valid seen in IDLE at cycle N -> ack/write_enable at N+1.
//    cmd_valid at N+2 -> next arbitration in the cycle after cmd_done.
//  New requests arriving while busy are not sampled until IDLE. The requester keeps req_valid high.
// CONFIGURATION
//  DDR_ARB_ERR_EN defined:
//    Adds output req_err [NUM_REQ].
//    In LOAD, if req_addr[grant][ALIGN_BITS-1:0] != 0: pulse req_err[grant] and req_ack[grant]
//    for 1 cycle, keep write_enable=0, return to IDLE, rr_ptr <= grant+1.
//    Reset value of req_err is 0.
//  DDR_ARB_ERR_EN undefined:
//    No req_err port. Addresses pass through unchecked. ALIGN_BITS is unused.
// TESTING
//  1. Single request: req_valid=4'b0001, addr0=0x0000_1000, write=1.
//     Expect in LOAD: write_enable=1, address=0x1000, req_ack=0001.
//     Expect next cycle: cmd_valid=1, cmd_write=1, cmd_id=0.
//     After cmd_ready then cmd_done: busy=0 and rr_ptr=1.
//  2. Round robin: all four requesting continuously, each burst completed.
//     Grant order 0,1,2,3,0; no requester is granted twice before the others.
//  3. Backpressure: hold cmd_ready=0 for 5 cycles in ISSUE.
//     cmd_valid, cmd_id and the hold-buffer address stay stable; write_enable stays 0.
//     Early cmd_done pulses during ISSUE are ignored.
//  4. Wrap and reset: grant requester 3 (rr_ptr wraps to 0).
//     Assert rst during WAIT_DONE: all outputs 0 asynchronously, state IDLE, rr_ptr 0.
//     Next request from port 2 is granted normally.
//  5. Abort: requester 1 drops req_valid in the LOAD cycle.
//     No req_ack, no write_enable, FSM returns to IDLE, requester 1 still first in line.
//  6. DDR_ARB_ERR_EN: addr2=0x0000_1002 with ALIGN_BITS=2.
//     Expect req_err=0100 and req_ack=0100, write_enable=0, no cmd_valid.
//     Without the macro the same stimulus runs a normal command with address 0x1002.

Source files
------------

// File: rtl/ddr_addr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_addr_arbiter: round-robin owner of the shared DDR address hold   |
// | buffer. Optional macro DDR_ARB_ERR_EN adds req_err_o for misaligned  |
// | addresses. Rev 1.0                                                   |
// +----------------------------------------------------------------------+
module ddr_addr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ALIGN_BITS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [32*NUM_REQ-1:0]      req_addr_i,
   input  logic [NUM_REQ-1:0]         req_write_i,
   output logic [NUM_REQ-1:0]         req_ack_o,
   output logic [31:0]                address_o,
   output logic                       write_enable_o,
   output logic                       cmd_valid_o,
   output logic                       cmd_write_o,
   output logic [$clog2(NUM_REQ)-1:0] cmd_id_o,
   input  logic                       cmd_ready_i,
   input  logic                       cmd_done_i,
   output logic                       busy_o
`ifdef DDR_ARB_ERR_EN
   ,
   output logic [NUM_REQ-1:0]         req_err_o
`endif
);

   localparam int             c_IDW  = $clog2(NUM_REQ);
   localparam int             c_SW   = c_IDW + 1;
   localparam logic [c_IDW-1:0] c_LAST = c_IDW'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || ALIGN_BITS < 1 || ALIGN_BITS > 31) begin : g_param_check
      $error("ddr_addr_arbiter: NUM_REQ or ALIGN_BITS out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t             state_q;
   logic [c_IDW-1:0]   grant_q;
   logic [c_IDW-1:0]   rr_ptr_q;
   logic               cmd_write_q;
   logic               cmd_valid_q;

   logic [c_IDW-1:0]   grant_d;
   logic [c_SW-1:0]    scan_idx;
   logic [c_IDW-1:0]   rr_next;
   logic [NUM_REQ-1:0] grant_oh;
   logic [31:0]        sel_addr;
   logic               sel_valid;
   logic               misalign;
   logic               load_accept;
   logic               load_ok;

   // Scan from the farthest offset back to rr_ptr so the closest requester wins.
   always_comb begin
      grant_d  = rr_ptr_q;
      scan_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_ptr_q} + c_SW'(k);
         if (scan_idx >= c_SW'(NUM_REQ)) scan_idx = scan_idx - c_SW'(NUM_REQ);
         if (req_valid_i[scan_idx[c_IDW-1:0]]) grant_d = scan_idx[c_IDW-1:0];
      end
   end

   assign rr_next   = (grant_q == c_LAST) ? '0 : grant_q + c_IDW'(1);
   assign grant_oh  = NUM_REQ'(1) << grant_q;
   assign sel_addr  = req_addr_i[32*grant_q +: 32];
   assign sel_valid = req_valid_i[grant_q];

`ifdef DDR_ARB_ERR_EN
   assign misalign  = |sel_addr[ALIGN_BITS-1:0];
`else
   assign misalign  = 1'b0;
`endif

   // A requester that drops valid during LOAD gets neither ack nor buffer write.
   assign load_accept = (state_q == S_LOAD) && sel_valid;
   assign load_ok     = load_accept && !misalign;

   assign req_ack_o      = load_accept ? grant_oh : '0;
   assign write_enable_o = load_ok;
   assign address_o      = load_ok ? sel_addr : 32'd0;
   assign cmd_valid_o    = cmd_valid_q;
   assign cmd_write_o    = cmd_write_q;
   assign cmd_id_o       = grant_q;
   assign busy_o         = (state_q != S_IDLE);

`ifdef DDR_ARB_ERR_EN
   assign req_err_o      = (load_accept && misalign) ? grant_oh : '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         cmd_write_q <= 1'b0;
         cmd_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|req_valid_i) begin
                  grant_q     <= grant_d;
                  cmd_write_q <= req_write_i[grant_d];
                  state_q     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (!sel_valid) begin
                  state_q <= S_IDLE;
               end else if (misalign) begin
                  state_q  <= S_IDLE;
                  rr_ptr_q <= rr_next;
               end else begin
                  state_q     <= S_ISSUE;
                  cmd_valid_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (cmd_ready_i) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cmd_done_i) begin
                  state_q  <= S_IDLE;
                  rr_ptr_q <= rr_next;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr_addr_arbiter.sv
`default_nettype none
// Bench for ddr_addr_arbiter: directed scenarios plus random traffic checked against a round-robin model.
module tb_ddr_addr_arbiter;
   localparam int N = 4;

   logic            clk       = 1'b0;
   logic            rst       = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_addr  = '0;
   logic [N-1:0]    req_write = '0;
   logic            cmd_ready = 1'b0;
   logic            cmd_done  = 1'b0;
   logic [N-1:0]    req_ack;
   logic [31:0]     address;
   logic            write_enable, cmd_valid, cmd_write, busy;
   logic [1:0]      cmd_id;
`ifdef DDR_ARB_ERR_EN
   logic [N-1:0]    req_err;
`endif

   int n_run  = 0;
   int n_fail = 0;

   // Reference state: round-robin pointer and the address each requester presents
   int          m_rr = 0;
   logic [31:0] m_addr [N];

   logic [N-1:0] ob_ack, ob_err;
   logic         ob_we, ob_cv, ob_cw, ob_busy;
   logic [31:0]  ob_addr;
   logic [1:0]   ob_id;
   int           ob_uns;

   always #5 clk = ~clk;

   ddr_addr_arbiter #(.NUM_REQ(N), .ALIGN_BITS(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_addr_i     (req_addr),
      .req_write_i    (req_write),
      .req_ack_o      (req_ack),
      .address_o      (address),
      .write_enable_o (write_enable),
      .cmd_valid_o    (cmd_valid),
      .cmd_write_o    (cmd_write),
      .cmd_id_o       (cmd_id),
      .cmd_ready_i    (cmd_ready),
      .cmd_done_i     (cmd_done),
      .busy_o         (busy)
`ifdef DDR_ARB_ERR_EN
      ,
      .req_err_o      (req_err)
`endif
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic int model_pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_rr + k) % N]) return (m_rr + k) % N;
      return 0;
   endfunction

   task automatic set_addr(input int i, input logic [31:0] a);
      m_addr[i] = a;
      req_addr[32*i +: 32] = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      @(negedge clk);
      m_rr = 0;
   endtask

   // Runs one arbitration from IDLE and records what the DUT showed; performs no judging itself.
   task automatic txn(input logic [N-1:0] v, input int rdy_dly, input bit early_done,
                      input bit expect_cmd, input logic [1:0] exp_id);
      req_valid = v;
      @(posedge clk); #1;
      @(negedge clk);
      ob_ack = req_ack; ob_we = write_enable; ob_addr = address;
`ifdef DDR_ARB_ERR_EN
      ob_err = req_err;
`else
      ob_err = '0;
`endif
      @(posedge clk); #1;
      if (!expect_cmd) req_valid = '0;
      @(negedge clk);
      ob_cv = cmd_valid; ob_id = cmd_id; ob_cw = cmd_write; ob_uns = 0;
      if (expect_cmd) begin
         for (int i = 0; i < rdy_dly; i++) begin
            cmd_done = early_done;
            @(posedge clk); #1;
            cmd_done = 1'b0;
            @(negedge clk);
            if (cmd_valid !== 1'b1 || cmd_id !== exp_id || write_enable !== 1'b0 || busy !== 1'b1)
               ob_uns++;
         end
         cmd_ready = 1'b1;
         cmd_done  = early_done;
         @(posedge clk); #1;
         cmd_ready = 1'b0;
         cmd_done  = 1'b0;
         @(negedge clk);
         if (cmd_valid !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) ob_uns++;
         cmd_done = 1'b1;
         @(posedge clk); #1;
         cmd_done = 1'b0;
         @(negedge clk);
      end
      ob_busy   = busy;
      req_valid = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_run++;
      if ({req_ack, address, write_enable, cmd_valid, cmd_write, cmd_id, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got ack=%b addr=%h we=%b cv=%b cw=%b id=%0d busy=%b exp all 0",
                  req_ack, address, write_enable, cmd_valid, cmd_write, cmd_id, busy);
      end
      rst = 1'b0;
      m_rr = 0;
      @(negedge clk);
      n_run++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle got busy=%b cv=%b exp 0 0", busy, cmd_valid);
      end
   endtask

   task automatic test_single();
      set_addr(0, 32'h0000_1000);
      req_write = 4'b0001;
      txn(4'b0001, 0, 1'b0, 1'b1, 2'd0);
      n_run++; if (ob_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", ob_ack); end
      n_run++; if (ob_we !== 1'b1) begin n_fail++; $display("FAIL single_we got=%b exp=1", ob_we); end
      n_run++; if (ob_addr !== 32'h1000) begin n_fail++; $display("FAIL single_addr got=%h exp=00001000", ob_addr); end
      n_run++; if ({ob_cv, ob_cw, ob_id} !== 4'b1100) begin
         n_fail++; $display("FAIL single_cmd got cv=%b cw=%b id=%0d exp cv=1 cw=1 id=0", ob_cv, ob_cw, ob_id);
      end
      n_run++; if (ob_busy !== 1'b0 || ob_uns !== 0) begin
         n_fail++; $display("FAIL single_done got busy=%b unstable=%0d exp 0 0", ob_busy, ob_uns);
      end
      m_rr = 1;
      // Pointer now at 1, so port 1 must beat port 0
      txn(4'b0011, 0, 1'b0, 1'b1, 2'd1);
      n_run++; if (ob_id !== 2'd1 || ob_ack !== 4'b0010) begin
         n_fail++; $display("FAIL single_rr_advance got id=%0d ack=%b exp id=1 ack=0010", ob_id, ob_ack);
      end
      m_rr = 2;
   endtask

   task automatic test_round_robin();
      logic [1:0] e_id;
      do_reset();
      for (int i = 0; i < N; i++) set_addr(i, 32'h0001_0000 * (i + 1));
      req_write = 4'b0101;
      for (int t = 0; t < 5; t++) begin
         e_id = 2'(t % N);
         txn(4'b1111, 1, 1'b0, 1'b1, e_id);
         n_run++;
         if (ob_id !== e_id || ob_ack !== (4'b0001 << e_id) || ob_addr !== m_addr[e_id]) begin
            n_fail++;
            $display("FAIL rr_order[%0d] got id=%0d ack=%b addr=%h exp id=%0d addr=%h",
                     t, ob_id, ob_ack, ob_addr, e_id, m_addr[e_id]);
         end
         m_rr = (e_id + 1) % N;
      end
   endtask

   task automatic test_backpressure();
      set_addr(2, 32'h0000_2200);
      req_write = 4'b0000;
      txn(4'b0100, 5, 1'b1, 1'b1, 2'd2);
      n_run++; if (ob_cv !== 1'b1 || ob_id !== 2'd2 || ob_cw !== 1'b0) begin
         n_fail++; $display("FAIL bp_issue got cv=%b id=%0d cw=%b exp 1 2 0", ob_cv, ob_id, ob_cw);
      end
      n_run++; if (ob_uns !== 0 || ob_busy !== 1'b0) begin
         n_fail++; $display("FAIL bp_stable got unstable=%0d busy=%b exp 0 0", ob_uns, ob_busy);
      end
      m_rr = 3;
   endtask

   task automatic test_wrap_reset();
      do_reset();
      set_addr(3, 32'h0000_3000);
      set_addr(0, 32'h0000_0400);
      set_addr(2, 32'h0000_2000);
      req_write = 4'b1000;
      txn(4'b1000, 0, 1'b0, 1'b1, 2'd3);
      m_rr = 0;
      txn(4'b1001, 0, 1'b0, 1'b1, 2'd0);
      n_run++; if (ob_id !== 2'd0) begin n_fail++; $display("FAIL wrap_to_zero got id=%0d exp=0", ob_id); end
      m_rr = 1;
      txn(4'b0100, 0, 1'b0, 1'b1, 2'd2);
      m_rr = 3;
      req_valid = 4'b1000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = '0;
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      n_run++; if (busy !== 1'b1 || cmd_id !== 2'd3 || cmd_write !== 1'b1) begin
         n_fail++; $display("FAIL wrap_pre_reset got busy=%b id=%0d cw=%b exp 1 3 1", busy, cmd_id, cmd_write);
      end
      #2;
      rst = 1'b1;
      #1;
      n_run++;
      if ({req_ack, address, write_enable, cmd_valid, cmd_write, cmd_id, busy} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got ack=%b addr=%h we=%b cv=%b cw=%b id=%0d busy=%b exp all 0",
                  req_ack, address, write_enable, cmd_valid, cmd_write, cmd_id, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      m_rr = 0;
      // From pointer 0 port 2 precedes port 3
      txn(4'b1100, 0, 1'b0, 1'b1, 2'd2);
      n_run++; if (ob_id !== 2'd2 || ob_ack !== 4'b0100 || ob_addr !== 32'h2000) begin
         n_fail++; $display("FAIL post_reset_grant got id=%0d ack=%b addr=%h exp 2 0100 00002000", ob_id, ob_ack, ob_addr);
      end
      m_rr = 3;
   endtask

   task automatic test_abort();
      do_reset();
      set_addr(1, 32'h0000_1100);
      txn(4'b0001, 0, 1'b0, 1'b1, 2'd0);
      m_rr = 1;
      req_valid = 4'b0010;
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      n_run++; if (req_ack !== 4'b0000 || write_enable !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL abort_load got ack=%b we=%b busy=%b exp 0000 0 1", req_ack, write_enable, busy);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_run++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle got busy=%b cv=%b exp 0 0", busy, cmd_valid);
      end
      txn(4'b1110, 0, 1'b0, 1'b1, 2'd1);
      n_run++; if (ob_id !== 2'd1 || ob_addr !== 32'h1100) begin
         n_fail++; $display("FAIL abort_first_in_line got id=%0d addr=%h exp 1 00001100", ob_id, ob_addr);
      end
      m_rr = 2;
   endtask

   task automatic test_align();
      set_addr(2, 32'h0000_1002);
      req_write = 4'b0100;
`ifdef DDR_ARB_ERR_EN
      txn(4'b0100, 0, 1'b0, 1'b0, 2'd2);
      n_run++; if (ob_err !== 4'b0100 || ob_ack !== 4'b0100 || ob_we !== 1'b0) begin
         n_fail++; $display("FAIL align_err got err=%b ack=%b we=%b exp 0100 0100 0", ob_err, ob_ack, ob_we);
      end
      n_run++; if (ob_cv !== 1'b0 || ob_busy !== 1'b0) begin
         n_fail++; $display("FAIL align_no_cmd got cv=%b busy=%b exp 0 0", ob_cv, ob_busy);
      end
      m_rr = 3;
      txn(4'b1001, 0, 1'b0, 1'b1, 2'd3);
      n_run++; if (ob_id !== 2'd3) begin n_fail++; $display("FAIL align_rr_advance got id=%0d exp=3", ob_id); end
      m_rr = 0;
`else
      txn(4'b0100, 0, 1'b0, 1'b1, 2'd2);
      n_run++; if (ob_ack !== 4'b0100 || ob_we !== 1'b1 || ob_addr !== 32'h1002) begin
         n_fail++; $display("FAIL unaligned_pass got ack=%b we=%b addr=%h exp 0100 1 00001002", ob_ack, ob_we, ob_addr);
      end
      n_run++; if (ob_cv !== 1'b1 || ob_id !== 2'd2 || ob_cw !== 1'b1) begin
         n_fail++; $display("FAIL unaligned_cmd got cv=%b id=%0d cw=%b exp 1 2 1", ob_cv, ob_id, ob_cw);
      end
      m_rr = 3;
`endif
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      logic [31:0]  a;
      int           g;
      bit           e_err;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            set_addr(i, a);
         end
         req_write = N'($urandom);
         v = N'($urandom_range(1, 15));
         g = model_pick(v);
`ifdef DDR_ARB_ERR_EN
         e_err = (m_addr[g][1:0] != 2'b00);
`else
         e_err = 1'b0;
`endif
         txn(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)), !e_err, 2'(g));
         n_run++;
         if (ob_ack !== (4'b0001 << g) || ob_we !== !e_err || ob_cv !== !e_err || ob_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand[%0d] v=%b got ack=%b we=%b cv=%b busy=%b exp grant=%0d err=%0d",
                     t, v, ob_ack, ob_we, ob_cv, ob_busy, g, e_err);
         end
         if (!e_err) begin
            n_run++;
            if (ob_addr !== m_addr[g] || ob_id !== 2'(g) || ob_cw !== req_write[g] || ob_uns !== 0) begin
               n_fail++;
               $display("FAIL rand_cmd[%0d] got addr=%h id=%0d cw=%b unstable=%0d exp addr=%h id=%0d cw=%b",
                        t, ob_addr, ob_id, ob_cw, ob_uns, m_addr[g], g, req_write[g]);
            end
         end
         m_rr = (g + 1) % N;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap_reset();
      test_abort();
      test_align();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
